// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on {hi, lo} accumulators.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    always_comb begin
        w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
        // Partial remainder stays below the divisor, so WIDTH+1 bits hold the signed trial result.
        w_shift = {i_hi, i_lo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_opnd};
        w_ge    = ~w_diff[WIDTH];
        if (i_div) begin
            o_hi = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], w_ge};
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO.
// Define MULDIV_ABORT_EN to add the 'abort' flush input.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc_hi, r_acc_lo, r_opnd, r_a_raw, r_hi, r_lo;
    logic               r_is_div, r_neg_res, r_neg_rem, r_div_zero, r_done;

    logic               w_abort, w_op_md, w_signed, w_a_neg, w_b_neg, w_last;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_step_hi, w_step_lo, w_fix_hi, w_fix_lo;
    logic [2*WIDTH-1:0] w_prod;

`ifdef MULDIV_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_op_md  = ~op[2];
    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_a_neg  = w_signed & A[WIDTH-1];
    assign w_b_neg  = w_signed & B[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -A : A;
    assign w_b_mag  = w_b_neg ? -B : B;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_div  (r_is_div),
        .i_hi   (r_acc_hi),
        .i_lo   (r_acc_lo),
        .i_opnd (r_opnd),
        .o_hi   (w_step_hi),
        .o_lo   (w_step_lo)
    );

    always_comb begin
        w_prod   = {r_acc_hi, r_acc_lo};
        w_fix_hi = '0;
        w_fix_lo = '0;
        if (!r_is_div) begin
            if (r_neg_res) w_prod = -w_prod;
            {w_fix_hi, w_fix_lo} = w_prod;
        end else if (r_div_zero) begin
            // Divide by zero reports the raw dividend, not its magnitude.
            w_fix_hi = r_a_raw;
            w_fix_lo = '1;
        end else begin
            w_fix_hi = r_neg_rem ? -r_acc_hi : r_acc_hi;
            w_fix_lo = r_neg_res ? -r_acc_lo : r_acc_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (start && !w_abort && w_op_md) w_state_next = ST_RUN;
            ST_RUN: begin
                if (w_abort)     w_state_next = ST_IDLE;
                else if (w_last) w_state_next = ST_FIX;
            end
            ST_FIX:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_opnd     <= '0;
            r_a_raw    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start && !w_abort) begin
                        if (w_op_md) begin
                            r_cnt      <= '0;
                            r_acc_hi   <= '0;
                            r_acc_lo   <= op[1] ? w_a_mag : w_b_mag;
                            r_opnd     <= op[1] ? w_b_mag : w_a_mag;
                            r_a_raw    <= A;
                            r_is_div   <= op[1];
                            r_neg_res  <= w_a_neg ^ w_b_neg;
                            r_neg_rem  <= w_a_neg;
                            r_div_zero <= (B == '0);
                        end else if (op == OP_MTHI) begin
                            r_hi <= A;
                        end else if (op == OP_MTLO) begin
                            r_lo <= A;
                        end
                    end
                end
                ST_RUN: begin
                    if (!w_abort) begin
                        r_acc_hi <= w_step_hi;
                        r_acc_lo <= w_step_lo;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                ST_FIX: begin
                    if (!w_abort) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic HI/LO reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
`ifdef MULDIV_ABORT_EN
    logic        abort;
`endif
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
`ifdef MULDIV_ABORT_EN
        .abort (abort),
`endif
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {hi, lo} from the architectural definition.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (o)
            3'd0: r = 64'(sa * sb);
            3'd1: r = {32'b0, a} * {32'b0, b};
            3'd2: if (b == 0) r = {a, 32'hFFFF_FFFF};
                  else        r = {32'(sa % sb), 32'(sa / sb)};
            3'd3: if (b == 0) r = {a, 32'hFFFF_FFFF};
                  else        r = {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Issues one op and follows it to completion; reports busy length and done shape.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int nbusy, output bit got_done, output bit busy_at_done,
                         output bit done_after);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        nbusy = 0; got_done = 1'b0; busy_at_done = 1'b0; done_after = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (busy) nbusy++;
            if (done) begin
                got_done = 1'b1;
                busy_at_done = busy;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [2:0]  ops [7] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd3, 3'd2, 3'd0};
        logic [31:0] as  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd5,
                                 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [7] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7, 32'd0,
                                 32'hFFFF_FFFF, 32'h8000_0000};
        logic [63:0] exp [7] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB,
                                 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                                 64'h0000_0005_FFFF_FFFF, 64'h0000_0000_8000_0000,
                                 64'h4000_0000_0000_0000};
        int nb; bit gd, bd, da;
        for (int i = 0; i < 7; i++) begin
            do_op(ops[i], as[i], bs[i], nb, gd, bd, da);
            checks++;
            if (!gd || nb != 33 || bd || da) begin
                errors++;
                $display("FAIL directed%0d_timing: busy_cycles=%0d done=%b busy@done=%b done_next=%b, want 33 1 0 0",
                         i, nb, gd, bd, da);
            end
            checks++;
            if ({hi, lo} !== exp[i]) begin
                errors++;
                $display("FAIL directed%0d_result: hi:lo=%h, want %h", i, {hi, lo}, exp[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0] o; logic [31:0] a, b; logic [63:0] e;
        int nb; bit gd, bd, da;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            e = model(o, a, b);
            do_op(o, a, b, nb, gd, bd, da);
            checks++;
            if (!gd || nb != 33 || {hi, lo} !== e) begin
                errors++;
                $display("FAIL random%0d op=%0d a=%h b=%h: hi:lo=%h busy=%0d done=%b, want %h 33 1",
                         i, o, a, b, {hi, lo}, nb, gd, e);
            end
        end
    endtask

    task automatic test_busy_ignore;
        logic [31:0] hi_prev;
        int nb; bit gd;
        hi_prev = hi;
        @(negedge clk);
        start = 1'b1; op = 3'd0; A = 32'hFFFF_FFFD; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        nb = 1; gd = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 4) begin start = 1'b1; op = 3'd1; A = 32'd1; B = 32'd1; end
            else if (i == 5) begin start = 1'b1; op = 3'd4; A = 32'hDEAD_BEEF; end
            else start = 1'b0;
            if (i == 7) begin
                checks++;
                if (hi !== hi_prev) begin
                    errors++;
                    $display("FAIL busy_hold_hi: hi=%h, want %h", hi, hi_prev);
                end
            end
            if (busy) nb++;
            if (done) begin gd = 1'b1; break; end
        end
        start = 1'b0;
        checks++;
        if (!gd || nb != 33 || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL busy_ignore: hi:lo=%h busy=%0d done=%b, want ffffffffffffffeb 33 1",
                     {hi, lo}, nb, gd);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_restart: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_mthi_mtlo;
        logic [31:0] lo_prev;
        lo_prev = lo;
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 32'h1234_5678;
        @(negedge clk);
        op = 3'd5; A = 32'h9ABC_DEF0;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== lo_prev || busy || done) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b, want 12345678 %h 0 0",
                     hi, lo, busy, done, lo_prev);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy || done) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, want 12345678 9abcdef0 0 0",
                     hi, lo, busy, done);
        end
        start = 1'b1; op = 3'd6; A = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy || done) begin
            errors++;
            $display("FAIL noop6: hi=%h lo=%h busy=%b done=%b, want unchanged idle", hi, lo, busy, done);
        end
    endtask

    task automatic test_reset_mid_run;
        bit saw_done;
        @(negedge clk);
        start = 1'b1; op = 3'd1; A = 32'hFFFF_FFFF; B = 32'h0000_0003;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy || done || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_mid_run_quiet: busy/done seen=1, want 0");
        end
    endtask

`ifdef MULDIV_ABORT_EN
    task automatic test_abort;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 32'hCAFE_0001;
        @(negedge clk);
        op = 3'd5; A = 32'hCAFE_0002;
        @(negedge clk);
        op = 3'd0; A = 32'h7; B = 32'h9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy || done || hi !== 32'hCAFE_0001 || lo !== 32'hCAFE_0002) begin
            errors++;
            $display("FAIL abort_run: busy=%b done=%b hi=%h lo=%h, want 0 0 cafe0001 cafe0002",
                     busy, done, hi, lo);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        start = 1'b1; abort = 1'b1; op = 3'd4; A = 32'h0BAD_0BAD;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (seen || busy || hi !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL abort_idle: seen=%b busy=%b hi=%h, want 0 0 cafe0001", seen, busy, hi);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_mthi_mtlo();
        test_reset_mid_run();
`ifdef MULDIV_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. It sits in the execute stage beside the ALU.
- It implements MIPS-style MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- The execute-stage result mux reads `hi`/`lo` for MFHI/MFLO through the ALU output mux slot 5, currently unused.
- The pipeline controller stalls on `busy`.

Parameters:
- WIDTH, 32, operand width and HI/LO register width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, request strobe, sampled on each rising edge.
- op, input, 3, operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- A, input, WIDTH, rs operand: multiplicand, dividend, or MTHI/MTLO source.
- B, input, WIDTH, rt operand: multiplier or divisor.
- busy, output, 1, high while a multiply/divide is in flight.
- done, output, 1, one-cycle pulse when HI/LO receive a multiply/divide result.
- hi, output, WIDTH, HI register.
- lo, output, WIDTH, LO register.

Behaviour:
- **Reset**
  - Clock `clk`, one domain. `reset` is synchronous and active-high.
  - During reset: state goes to IDLE; `busy`, `done`, `hi`, `lo` and the counter all go to 0.
  - Reset mid-operation discards the computation; HI/LO go to 0.
- **States:** IDLE, RUN, FIX.
  - IDLE with start=1 and op in 0..3: at edge k, latch the operand magnitudes and the result/remainder sign flags, clear the accumulators, set counter=0, go to RUN.
  - RUN: one radix-2 step per edge; edges k+1..k+WIDTH. After the WIDTH-th step, go to FIX.
  - FIX: at edge k+WIDTH+1, apply sign correction, write `hi`/`lo`, register done=1, go to IDLE.
- **Timing**
  - `busy` = (state != IDLE). It is high for WIDTH+1 cycles (33 by default).
  - `done` is high exactly one cycle, after edge k+WIDTH+1. It coincides with busy=0 and new `hi`/`lo`.
  - `hi`/`lo` hold their old values throughout RUN. All arithmetic uses internal accumulators.
  - start=1 while busy=1 is ignored entirely. The pipeline guarantees a stall, but the unit must not corrupt state.
- **MTHI/MTLO**
  - Accepted only in IDLE. The write takes effect at the sampling edge.
  - They do not assert busy or done.
  - MTHI and MTLO each leave the other register unchanged.
- **Multiply**
  - Shift-add over a 2*WIDTH product. Result is {hi, lo} = full 2*WIDTH product.
  - MULT: signed, via magnitudes, with the product negated if the signs differ.
- **Divide**
  - Restoring division on magnitudes. lo = quotient, hi = remainder.
  - DIV: quotient is negative iff the operand signs differ; the remainder takes the sign of the dividend.
- **Boundaries**
  - Divide by zero (DIV or DIVU): lo = all ones, hi = A (as given, not its magnitude). Latency is unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - MULT 0x80000000 * 0x80000000: {hi, lo} = 0x40000000_00000000.
  - Latency is fixed and data-independent.

Optional Feature:
- Macro: `MULDIV_ABORT_EN`.
- With the macro, an extra input port `abort` (1 bit) exists:
  - abort=1 in RUN or FIX returns the unit to IDLE at that edge. `hi`/`lo` are untouched and done stays 0.
  - abort=1 in IDLE blocks a same-cycle start, including MTHI/MTLO.
  - Used for pipeline flush on exceptions.
- Without the macro: no `abort` port, and an operation always runs to completion.

Decomposition:
- Shared package `muldiv_pkg` holds:
  - the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO);
  - the state encoding (ST_IDLE, ST_RUN, ST_FIX);
  - the default WIDTH.
- One sub-module, `muldiv_step`: purely combinational, one iteration.
  - Multiply mode: conditional add, then shift right.
  - Divide mode: trial subtract, restore, then shift in the quotient bit.
  - The FSM, counter and sign fixing stay in `muldiv_unit`.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 33 busy cycles, done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. A second start during busy (A=1, B=1) is ignored and the result is unchanged.
- DIV A=0xFFFFFFF9 (-7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- DIVU A=5, B=0 → lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → both visible the cycle after each edge; busy and done never assert.
- Reset asserted at RUN cycle 10 → next cycle busy=0, hi=lo=0, no done. With `MULDIV_ABORT_EN`: abort at cycle 10 → hi/lo keep their prior values, no done.
